ram_pipe: RTL and testbench

- Parametrised single-port synchronous RAM; successor to the fixed 32x8 RAM.
- Configurable data width, depth and read latency.
- Hardware clear sweep after reset, ready/valid handshake, out-of-range error flag.
- Sits between the controller FSM and storage; the controller issues one request per cycle while mem_ready is high.

---
 rtl/ram_pipe.sv | 132 +++++++++++++
 tb/tb_ram_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_pipe.sv
// Parametrised single-port synchronous RAM with a post-reset clear sweep,
// a fixed-latency read pipeline and an out-of-range error pulse.
module ram_pipe #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DEPTH    = 32,
  parameter int unsigned       READ_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_ram,
  input  logic              mem_control,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_valid,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam int unsigned LAST  = READ_LAT - 1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [IDX_W-1:0]  cnt, cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, in_range, acc_rd, rd_oor, wr_oor;
  logic [IDX_W-1:0]  mem_idx;
  logic              we;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic [READ_LAT-1:0] pv_q, pv_nxt;
  logic [READ_LAT-1:0] pe_q, pe_nxt;
  logic [DATA_W-1:0]   pd_q   [READ_LAT];
  logic [DATA_W-1:0]   pd_nxt [READ_LAT];

  // Request decode; the one-bit-wider compare lets DEPTH equal 2^ADDR_W.
  assign accept   = request_ram & mem_ready;
  assign in_range = {1'b0, mem_addr} < CMP_W'(DEPTH);
  assign mem_idx  = mem_addr[IDX_W-1:0];
  assign acc_rd   = accept & mem_control;
  assign rd_oor   = acc_rd & ~in_range;
  assign wr_oor   = accept & ~mem_control & ~in_range;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      mem_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_ready <= (state_nxt == ST_READY);
    end
  end

  // Next state and write-port selection: sweep owns the port during INIT
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we        = 1'b0;
    wr_idx    = mem_idx;
    wr_data   = mem_data_in;
    case (state)
      ST_INIT: begin
        we      = 1'b1;
        wr_idx  = cnt;
        wr_data = INIT_VAL;
        if (cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt = ST_READY;
        end else begin
          cnt_nxt = cnt + IDX_W'(1);
        end
      end
      default: begin
        we = accept & ~mem_control & in_range;
      end
    endcase
  end

  // Storage array, no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read pipeline next values; write errors join at the output stage
  always_comb begin
    pv_nxt    = '0;
    pe_nxt    = '0;
    pv_nxt[0] = acc_rd;
    pe_nxt[0] = rd_oor;
    pd_nxt[0] = (acc_rd && in_range) ? mem[mem_idx] : '0;
    for (int i = 1; i < READ_LAT; i++) begin
      pv_nxt[i] = pv_q[i-1];
      pe_nxt[i] = pe_q[i-1];
      pd_nxt[i] = pd_q[i-1];
    end
    pe_nxt[LAST] = pe_nxt[LAST] | wr_oor;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q <= pv_nxt;
      pe_q <= pe_nxt;
      for (int i = 0; i < READ_LAT; i++) begin
        pd_q[i] <= pd_nxt[i];
      end
    end
  end

  assign mem_valid    = pv_q[LAST];
  assign mem_err      = pe_q[LAST];
  assign mem_data_out = pd_q[LAST];

endmodule

// File: tb/tb_ram_pipe.sv
// Directed bench: four ram_pipe instances (latency 1/2/3 and a wide/deep one)
// driven by shared stimulus and checked against hand-computed values.
module tb_ram_pipe;

  logic        clk, rst, req, ctrl;
  logic [11:0] addr;
  logic [15:0] din;

  logic [7:0]  do1, do2, do3;
  logic [15:0] dow;
  logic        v1, v2, v3, vw;
  logic        r1, r2, r3, rw;
  logic        e1, e2, e3, ew;

  int n_chk = 0;
  int n_bad = 0;

  int exp_v1 [7] = '{1, 1, 1, 1, 0, 0, 0};
  int exp_d1 [7] = '{3, 9, 7, 2, 0, 0, 0};
  int exp_v3 [7] = '{0, 0, 1, 1, 1, 1, 0};
  int exp_d3 [7] = '{0, 0, 3, 9, 7, 2, 0};

  ram_pipe u_lat1 (
    .clk(clk), .rst(rst), .request_ram(req), .mem_control(ctrl), .mem_addr(addr),
    .mem_data_in(din[7:0]), .mem_data_out(do1), .mem_valid(v1), .mem_ready(r1), .mem_err(e1)
  );

  ram_pipe #(.READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .request_ram(req), .mem_control(ctrl), .mem_addr(addr),
    .mem_data_in(din[7:0]), .mem_data_out(do2), .mem_valid(v2), .mem_ready(r2), .mem_err(e2)
  );

  ram_pipe #(.READ_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .request_ram(req), .mem_control(ctrl), .mem_addr(addr),
    .mem_data_in(din[7:0]), .mem_data_out(do3), .mem_valid(v3), .mem_ready(r3), .mem_err(e3)
  );

  ram_pipe #(.DATA_W(16), .DEPTH(1024), .INIT_VAL(16'hFFFF)) u_wide (
    .clk(clk), .rst(rst), .request_ram(req), .mem_control(ctrl), .mem_addr(addr),
    .mem_data_in(din), .mem_data_out(dow), .mem_valid(vw), .mem_ready(rw), .mem_err(ew)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request for one edge, then idle
  task automatic op(input logic c, input int a, input int d);
    req  = 1'b1;
    ctrl = c;
    addr = 12'(a);
    din  = 16'(d);
    tick();
    req  = 1'b0;
  endtask

  initial begin
    int rdy1_at, rdy2_at, rdy3_at, rdyw_at, quiet_bad, nv;
    logic [7:0] acc;

    rst = 1'b0; req = 1'b0; ctrl = 1'b0; addr = '0; din = '0;
    repeat (3) tick();
    check("rst_ready", 32'(r1), 0);
    check("rst_valid", 32'(v1), 0);
    check("rst_err",   32'(e1), 0);
    check("rst_data",  32'(do1), 0);
    check("rst_ready_wide", 32'(rw), 0);

    // Init sweep with requests held high; all of them must be ignored
    rdy1_at = 0; rdy2_at = 0; rdy3_at = 0; rdyw_at = 0; quiet_bad = 0;
    req = 1'b1; addr = 12'd3; din = 16'h5A5A;
    rst = 1'b1;
    for (int k = 1; k <= 1030; k++) begin
      ctrl = k[0];
      if (k == 33) req = 1'b0;
      tick();
      if (r1 && rdy1_at == 0) rdy1_at = k;
      if (r2 && rdy2_at == 0) rdy2_at = k;
      if (r3 && rdy3_at == 0) rdy3_at = k;
      if (rw && rdyw_at == 0) rdyw_at = k;
      if (v1 | v2 | v3 | vw | e1 | e2 | e3 | ew) quiet_bad++;
    end
    check("init_cycles_lat1", 32'(rdy1_at), 32);
    check("init_cycles_lat2", 32'(rdy2_at), 32);
    check("init_cycles_lat3", 32'(rdy3_at), 32);
    check("init_cycles_wide", 32'(rdyw_at), 1024);
    check("init_quiet", 32'(quiet_bad), 0);

    // Every word cleared, including addr 3 that saw ignored writes
    acc = '0; nv = 0;
    for (int a = 0; a < 32; a++) begin
      op(1'b1, a, 0);
      if (v1) nv++;
      acc = acc | do1;
    end
    check("sweep_valid_count", 32'(nv), 32);
    check("sweep_data_or", 32'(acc), 0);
    repeat (4) tick();

    // Wide/deep instance: init value, overwrite, top-of-range error
    op(1'b1, 1023, 0);
    check("wide_init_valid", 32'(vw), 1);
    check("wide_init_data", 32'(dow), 32'h0000FFFF);
    op(1'b0, 1023, 16'h1234);
    op(1'b1, 1023, 0);
    check("wide_rdback", 32'(dow), 32'h00001234);
    op(1'b1, 1024, 0);
    check("wide_oor_err", 32'(ew), 1);
    check("wide_oor_valid", 32'(vw), 1);
    check("wide_oor_data", 32'(dow), 0);
    repeat (4) tick();

    // Latency 1: write then read next cycle
    op(1'b0, 0, 8'h03);
    op(1'b0, 1, 8'h09);
    op(1'b1, 1, 0);
    check("lat1_valid", 32'(v1), 1);
    check("lat1_data", 32'(do1), 32'h09);
    tick();
    check("lat1_idle_valid", 32'(v1), 0);
    check("lat1_idle_data", 32'(do1), 0);
    op(1'b1, 0, 0);
    check("lat1_addr0", 32'(do1), 32'h03);
    repeat (4) tick();

    // Back-to-back reads, latency 1 and 3 in order
    op(1'b0, 2, 8'h07);
    op(1'b0, 3, 8'h02);
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        req = 1'b1; ctrl = 1'b1; addr = 12'(c);
      end else begin
        req = 1'b0;
      end
      tick();
      check("burst_lat1_valid", 32'(v1), 32'(exp_v1[c]));
      check("burst_lat1_data", 32'(do1), 32'(exp_d1[c]));
      check("burst_lat3_valid", 32'(v3), 32'(exp_v3[c]));
      check("burst_lat3_data", 32'(do3), 32'(exp_d3[c]));
    end
    req = 1'b0;
    repeat (4) tick();

    // Out-of-range write must not alias onto addr 8
    op(1'b0, 8, 8'h88);
    op(1'b0, 40, 8'hAA);
    check("oor_wr_err", 32'(e1), 1);
    check("oor_wr_novalid", 32'(v1), 0);
    tick();
    check("oor_wr_err_pulse", 32'(e1), 0);
    op(1'b1, 8, 0);
    check("oor_no_alias", 32'(do1), 32'h88);
    op(1'b1, 40, 0);
    check("oor_rd_valid", 32'(v1), 1);
    check("oor_rd_err", 32'(e1), 1);
    check("oor_rd_data", 32'(do1), 0);
    tick();
    check("oor_rd_err_pulse", 32'(e1), 0);
    check("lat3_addr8", 32'(do3), 32'h88);
    tick();
    check("lat3_oor_valid", 32'(v3), 1);
    check("lat3_oor_err", 32'(e3), 1);
    check("lat3_oor_data", 32'(do3), 0);
    repeat (4) tick();

    // Reset with reads in flight
    op(1'b1, 0, 0);
    req = 1'b1; ctrl = 1'b1; addr = 12'd1;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(r2), 0);
    check("midrst_valid", 32'(v2), 0);
    tick();
    check("midrst_lat2_valid", 32'(v2), 0);
    check("midrst_lat3_valid", 32'(v3), 0);
    req = 1'b0;
    rst = 1'b1;
    rdy2_at = 0; quiet_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (r2 && rdy2_at == 0) rdy2_at = k;
      if (v2 | v3 | e2 | e3) quiet_bad++;
    end
    check("midrst_dropped", 32'(quiet_bad), 0);
    check("midrst_reinit_cycles", 32'(rdy2_at), 32);
    op(1'b1, 0, 0);
    tick();
    check("midrst_reread_valid", 32'(v2), 1);
    check("midrst_reread_data", 32'(do2), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
